// File: rtl/gray_to_bin_tracker.sv
// Registered Gray-to-binary decoder with single-step legality tracking.
// Two stages: input capture, then decode/check into registered outputs.
module gray_to_bin_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir_up,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count,
    output logic             tracking
);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t             state_q, state_d;
    logic               s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0]   s1_gray_q, s1_gray_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   bin_new;
    logic [WIDTH-1:0]   delta;
    logic               step_up, step_dn, step_hold;

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign bin_new[i] = ^s1_gray_q[WIDTH-1:i];
    end

    // bin_q always holds the last result, so it doubles as the reference code.
    assign delta     = bin_new - bin_q;
    assign step_up   = (delta == WIDTH'(1));
    assign step_dn   = (delta == {WIDTH{1'b1}});
    assign step_hold = (delta == '0);

    always_comb begin
        s1_vld_d    = in_valid;
        s1_gray_d   = in_valid ? gray_in : s1_gray_q;
        state_d     = state_q;
        out_valid_d = 1'b0;
        bin_d       = bin_q;
        dir_d       = dir_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        if (s1_vld_q) begin
            out_valid_d = 1'b1;
            bin_d       = bin_new;
            state_d     = TRACK;
            if (state_q == TRACK && !clear) begin
                if (step_up) begin
                    dir_d = 1'b1;
                end else if (step_dn) begin
                    dir_d = 1'b0;
                end else if (!step_hold) begin
                    err_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // A result leaving stage 2 on the clear edge becomes the fresh reference.
        if (clear) begin
            cnt_d = '0;
            if (!s1_vld_q) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_vld_q    <= 1'b0;
            s1_gray_q   <= '0;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_vld_q    <= s1_vld_d;
            s1_gray_q   <= s1_gray_d;
            out_valid_q <= out_valid_d;
            bin_q       <= bin_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign dir_up    = dir_q;
    assign step_err  = err_q;
    assign err_count = cnt_q;
    assign tracking  = (state_q == TRACK);

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// Bench for gray_to_bin_tracker: behavioural model feeds a result queue,
// a second instance with a 2-bit counter exercises saturation.
module tb_gray_to_bin_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] gray_in = 4'd0;

    logic       out_valid, dir_up, step_err, tracking;
    logic [3:0] bin_out;
    logic [7:0] err_count;

    logic       s_out_valid, s_dir_up, s_step_err, s_tracking;
    logic [3:0] s_bin_out;
    logic [1:0] s_err_count;

    always #5 clk = ~clk;

    gray_to_bin_tracker #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .gray_in(gray_in),
        .out_valid(out_valid), .bin_out(bin_out), .dir_up(dir_up), .step_err(step_err),
        .err_count(err_count), .tracking(tracking)
    );

    gray_to_bin_tracker #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .gray_in(gray_in),
        .out_valid(s_out_valid), .bin_out(s_bin_out), .dir_up(s_dir_up), .step_err(s_step_err),
        .err_count(s_err_count), .tracking(s_tracking)
    );

    typedef struct {
        logic [3:0] bin;
        logic       err;
        logic       dir;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    logic [3:0] m_prev = 4'd0;
    logic       m_track = 1'b0;
    logic       m_dir = 1'b0;
    logic [7:0] m_cnt8 = 8'd0;
    logic [1:0] m_cnt2 = 2'd0;
    logic       pv = 1'b0;
    logic [3:0] pg = 4'd0;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b, s;
        b = 4'd0;
        s = g;
        for (int k = 0; k < 4; k++) begin
            b = b ^ s;
            s = s >> 1;
        end
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        sb.delete();
        m_prev = 4'd0; m_track = 1'b0; m_dir = 1'b0;
        m_cnt8 = 8'd0; m_cnt2 = 2'd0; pv = 1'b0; pg = 4'd0;
    endtask

    // One clock: drive inputs, advance the model at the edge, then score the result.
    task automatic cyc(input logic v, input logic [3:0] g, input logic c);
        exp_t       e;
        logic [3:0] b, d;
        logic       exp_v;
        in_valid = v; gray_in = g; clear = c;
        @(posedge clk);
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                b = g2b(pg);
                e.err = 1'b0;
                if (m_track && !c) begin
                    d = b - m_prev;
                    if (d == 4'd1) m_dir = 1'b1;
                    else if (d == 4'd15) m_dir = 1'b0;
                    else if (d != 4'd0) begin
                        e.err = 1'b1;
                        if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
                        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
                    end
                end
                m_prev = b;
                m_track = 1'b1;
                if (c) begin m_cnt8 = 8'd0; m_cnt2 = 2'd0; end
                e.bin = b; e.dir = m_dir; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2;
                sb.push_back(e);
            end else if (c) begin
                m_track = 1'b0; m_cnt8 = 8'd0; m_cnt2 = 2'd0;
            end
            pv = v; pg = g;
        end
        #1;
        if (!rst) begin
            exp_v = (sb.size() != 0);
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL out_valid: got %b want %b", out_valid, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                total++;
                if (bin_out !== e.bin) begin
                    bad++; $display("FAIL bin_out: got %h want %h", bin_out, e.bin);
                end
                total++;
                if (step_err !== e.err) begin
                    bad++; $display("FAIL step_err: got %b want %b (bin %h)", step_err, e.err, e.bin);
                end
                total++;
                if (dir_up !== e.dir) begin
                    bad++; $display("FAIL dir_up: got %b want %b (bin %h)", dir_up, e.dir, e.bin);
                end
                total++;
                if (err_count !== e.cnt8) begin
                    bad++; $display("FAIL err_count: got %0d want %0d", err_count, e.cnt8);
                end
                total++;
                if (s_err_count !== e.cnt2) begin
                    bad++; $display("FAIL sat_err_count: got %0d want %0d", s_err_count, e.cnt2);
                end
            end else begin
                total++;
                if (step_err !== 1'b0) begin
                    bad++; $display("FAIL idle_step_err: got %b want 0", step_err);
                end
            end
            total++;
            if (tracking !== m_track) begin
                bad++; $display("FAIL tracking: got %b want %b", tracking, m_track);
            end
        end
    endtask

    task automatic idle_clear();
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'b1010, 1'b0);
            total++;
            if ({out_valid, step_err, dir_up, tracking, bin_out, err_count} !== 16'd0) begin
                bad++;
                $display("FAIL reset_outputs: got ov=%b se=%b du=%b tr=%b bin=%h cnt=%0d want all 0",
                         out_valid, step_err, dir_up, tracking, bin_out, err_count);
            end
        end
        rst = 1'b0;
        cyc(1'b1, 4'b1010, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL first_latency: out_valid got %b want 0 one edge after sample", out_valid);
        end
        cyc(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_up_sweep();
        idle_clear();
        for (int i = 0; i < 16; i++) cyc(1'b1, b2g(4'(i)), 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        total++;
        if (err_count !== 8'd0 || dir_up !== 1'b1 || bin_out !== 4'd0) begin
            bad++; $display("FAIL up_sweep_end: got cnt=%0d dir=%b bin=%h want 0 1 0", err_count, dir_up, bin_out);
        end
    endtask

    task automatic test_down_hold();
        idle_clear();
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        total++;
        if (dir_up !== 1'b0 || err_count !== 8'd0 || bin_out !== 4'd1) begin
            bad++; $display("FAIL down_hold: got dir=%b cnt=%0d bin=%h want 0 0 1", dir_up, err_count, bin_out);
        end
    endtask

    task automatic test_illegal();
        idle_clear();
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0);
        total++;
        if (step_err !== 1'b1 || bin_out !== 4'b0010) begin
            bad++; $display("FAIL illegal_jump: got se=%b bin=%h want 1 2", step_err, bin_out);
        end
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        total++;
        if (err_count !== 8'd1 || bin_out !== 4'd3) begin
            bad++; $display("FAIL illegal_after: got cnt=%0d bin=%h want 1 3", err_count, bin_out);
        end
    endtask

    task automatic test_saturation();
        idle_clear();
        for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        total++;
        if (s_err_count !== 2'd3 || err_count !== 8'd5) begin
            bad++; $display("FAIL saturation: got sat=%0d wide=%0d want 3 5", s_err_count, err_count);
        end
    endtask

    task automatic test_clear_reset();
        idle_clear();
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b1100, 1'b0);
        cyc(1'b0, 4'd0, 1'b1);
        total++;
        if (bin_out !== 4'b1000 || step_err !== 1'b0 || err_count !== 8'd0 || tracking !== 1'b1) begin
            bad++; $display("FAIL clear_inflight: got bin=%h se=%b cnt=%0d tr=%b want 8 0 0 1",
                            bin_out, step_err, err_count, tracking);
        end
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({out_valid, step_err, dir_up, tracking, bin_out, err_count} !== 16'd0) begin
            bad++; $display("FAIL async_reset: got ov=%b se=%b du=%b tr=%b bin=%h cnt=%0d want all 0",
                            out_valid, step_err, dir_up, tracking, bin_out, err_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 4'b0110, 1'b0);
        cyc(1'b1, 4'b0111, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        total++;
        if (err_count !== 8'd0 || bin_out !== 4'd5 || dir_up !== 1'b1) begin
            bad++; $display("FAIL post_reset: got cnt=%0d bin=%h dir=%b want 0 5 1", err_count, bin_out, dir_up);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] cur;
        int         r;
        cur = 4'd7;
        idle_clear();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) cur = cur + 4'd1;
            else if (r < 7) cur = cur - 4'd1;
            else if (r == 9) cur = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, b2g(cur), $urandom_range(0, 19) == 0);
        end
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_hold();
        test_illegal();
        test_saturation();
        test_clear_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
